// File: rtl/wb_comp.sv
// Core-side compressed wishbone bridge: serializes 16-bit wishbone requests onto the
// multiplexed cw pins (addr lo, addr hi + sel, write data) and returns the far-end response.
module wb_comp #(
   parameter int unsigned ADDR_W  = 24,
   parameter int unsigned DATA_W  = 16,
   parameter int unsigned TIMEOUT = 255
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              wb_cyc,
   input  logic              wb_stb,
   input  logic              wb_we,
   input  logic [ADDR_W-1:0] wb_adr,
   input  logic [1:0]        wb_sel,
   input  logic [DATA_W-1:0] wb_i_dat,
   output logic [DATA_W-1:0] wb_o_dat,
   output logic              wb_ack,
   output logic              wb_err,
   output logic              cw_req,
   output logic              cw_dir,
   output logic [DATA_W-1:0] cw_io_o,
   input  logic [DATA_W-1:0] cw_io_i,
   input  logic              cw_ack,
   input  logic              cw_err,
   output logic              cw_clk,
   output logic              cw_rst
);

   localparam int unsigned CntW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

   // Each state names the beat currently on the pins; StLat is the cycle after acceptance.
   typedef enum logic [2:0] {
      StIdle, StLat, StAlo, StAhi, StData, StWait, StDone
   } state_e;

   state_e              state_q, state_d;
   logic                we_q, we_d;
   logic [ADDR_W-1:0]   adr_q, adr_d;
   logic [1:0]          sel_q, sel_d;
   logic [DATA_W-1:0]   dat_q, dat_d;
   logic [CntW-1:0]     cnt_q, cnt_d;
   logic                abort_q, abort_d;
   logic                cw_req_q, cw_req_d;
   logic                cw_dir_q, cw_dir_d;
   logic [DATA_W-1:0]   cw_io_q, cw_io_d;
   logic                wb_ack_q, wb_ack_d;
   logic                wb_err_q, wb_err_d;
   logic [DATA_W-1:0]   wb_dat_q, wb_dat_d;
   logic [23:0]         adr24;
   logic                abort_now;

   assign adr24     = 24'(adr_q);
   assign abort_now = abort_q | ~wb_cyc;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q  <= StIdle;
         we_q     <= 1'b0;
         adr_q    <= '0;
         sel_q    <= '0;
         dat_q    <= '0;
         cnt_q    <= '0;
         abort_q  <= 1'b0;
         cw_req_q <= 1'b0;
         cw_dir_q <= 1'b0;
         cw_io_q  <= '0;
         wb_ack_q <= 1'b0;
         wb_err_q <= 1'b0;
         wb_dat_q <= '0;
      end else begin
         state_q  <= state_d;
         we_q     <= we_d;
         adr_q    <= adr_d;
         sel_q    <= sel_d;
         dat_q    <= dat_d;
         cnt_q    <= cnt_d;
         abort_q  <= abort_d;
         cw_req_q <= cw_req_d;
         cw_dir_q <= cw_dir_d;
         cw_io_q  <= cw_io_d;
         wb_ack_q <= wb_ack_d;
         wb_err_q <= wb_err_d;
         wb_dat_q <= wb_dat_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      we_d     = we_q;
      adr_d    = adr_q;
      sel_d    = sel_q;
      dat_d    = dat_q;
      cnt_d    = cnt_q;
      abort_d  = abort_now;
      cw_req_d = 1'b0;
      cw_dir_d = cw_dir_q;
      cw_io_d  = '0;
      wb_ack_d = 1'b0;
      wb_err_d = 1'b0;
      wb_dat_d = wb_dat_q;

      unique case (state_q)
         StIdle: begin
            abort_d = 1'b0;
            if (wb_cyc && wb_stb) begin
               we_d    = wb_we;
               adr_d   = wb_adr;
               sel_d   = wb_sel;
               dat_d   = wb_i_dat;
               state_d = StLat;
            end
         end
         StLat: begin
            cw_req_d = 1'b1;
            cw_dir_d = we_q;
            cw_io_d  = DATA_W'(adr24[15:0]);
            state_d  = StAlo;
         end
         StAlo: begin
            cw_io_d = DATA_W'({sel_q, 6'b0, adr24[23:16]});
            state_d = StAhi;
         end
         StAhi: begin
            cnt_d = '0;
            if (we_q) begin
               cw_io_d = dat_q;
               state_d = StData;
            end else begin
               state_d = StWait;
            end
         end
         StData: begin
            state_d = StWait;
         end
         StWait: begin
            cnt_d = cnt_q + CntW'(1);
            // err outranks ack, and a far-end response outranks the local timeout
            if (cw_err) begin
               wb_err_d = ~abort_now;
               state_d  = StDone;
            end else if (cw_ack) begin
               wb_ack_d = ~abort_now;
               if (!we_q && !abort_now) begin
                  wb_dat_d = cw_io_i;
               end
               state_d = StDone;
            end else if ((TIMEOUT != 0) && (cnt_d == CntW'(TIMEOUT))) begin
               wb_err_d = ~abort_now;
               state_d  = StDone;
            end
         end
         StDone: begin
            cw_dir_d = 1'b0;
            cnt_d    = '0;
            state_d  = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   assign wb_o_dat = wb_dat_q;
   assign wb_ack   = wb_ack_q;
   assign wb_err   = wb_err_q;
   assign cw_req   = cw_req_q;
   assign cw_dir   = cw_dir_q;
   assign cw_io_o  = cw_io_q;
   assign cw_clk   = i_clk;
   assign cw_rst   = i_rst;

endmodule

// File: tb/tb_wb_comp.sv
// Randomized self-checking bench for wb_comp: a transaction-level timing model predicts
// every registered output per cycle; a negedge process compares, directed cases pin literals.
module tb_wb_comp;

   localparam int unsigned AW = 24;
   localparam int unsigned DW = 16;
   localparam int unsigned TO = 8;

   logic          clk = 1'b0;
   logic          i_rst;
   logic          wb_cyc, wb_stb, wb_we;
   logic [AW-1:0] wb_adr;
   logic [1:0]    wb_sel;
   logic [DW-1:0] wb_i_dat, wb_o_dat;
   logic          wb_ack, wb_err;
   logic          cw_req, cw_dir;
   logic [DW-1:0] cw_io_o, cw_io_i;
   logic          cw_ack, cw_err, cw_clk, cw_rst;

   always #5 clk = ~clk;

   wb_comp #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
      .i_clk(clk), .i_rst(i_rst),
      .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we), .wb_adr(wb_adr), .wb_sel(wb_sel),
      .wb_i_dat(wb_i_dat), .wb_o_dat(wb_o_dat), .wb_ack(wb_ack), .wb_err(wb_err),
      .cw_req(cw_req), .cw_dir(cw_dir), .cw_io_o(cw_io_o), .cw_io_i(cw_io_i),
      .cw_ack(cw_ack), .cw_err(cw_err), .cw_clk(cw_clk), .cw_rst(cw_rst)
   );

   int          n_chk = 0;
   int          n_fail = 0;
   logic        chk_en = 1'b0;
   logic        exp_req, exp_dir, exp_ack, exp_err;
   logic [15:0] exp_io, exp_odat;

   int          cyc = 0;
   int          req_cnt = 0;
   int          last_req_cyc = -100;
   int          req_gap = 0;
   int          obs_ack, obs_err, done_i;
   logic [15:0] beat [3];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s at %0t: got %h, want %h", name, $time, act, req);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         check("cw_req", 32'(cw_req), 32'(exp_req));
         check("cw_dir", 32'(cw_dir), 32'(exp_dir));
         check("cw_io_o", 32'(cw_io_o), 32'(exp_io));
         check("wb_ack", 32'(wb_ack), 32'(exp_ack));
         check("wb_err", 32'(wb_err), 32'(exp_err));
         check("wb_o_dat", 32'(wb_o_dat), 32'(exp_odat));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
      if (cw_req) begin
         req_cnt++;
         req_gap = cyc - last_req_cyc;
         last_req_cyc = cyc;
      end
   endtask

   task automatic set_idle();
      exp_req = 1'b0; exp_dir = 1'b0; exp_io = '0; exp_ack = 1'b0; exp_err = 1'b0;
   endtask

   task automatic junk();
      cw_ack = 1'($urandom_range(0, 1));
      cw_err = 1'($urandom_range(0, 1));
      cw_io_i = 16'($urandom);
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) begin
         wb_cyc = 1'($urandom_range(0, 1));
         wb_stb = ~wb_cyc & 1'($urandom_range(0, 1));
         wb_we = 1'($urandom_range(0, 1));
         wb_adr = AW'($urandom);
         junk();
         tick();
         set_idle();
      end
      wb_cyc = 1'b0; wb_stb = 1'b0;
   endtask

   // kind: 0 ack, 1 err, 2 ack+err, 3 silent (timeout). delay: WAIT cycles before response.
   task automatic txn(input logic we, input logic [23:0] adr, input logic [1:0] sel,
                      input logic [15:0] dat, input logic [15:0] rdat, input int delay,
                      input int kind, input bit keep_stb, input int abort_at, input bit rst_dat);
      logic [15:0] rd;
      bit          resp, is_err, ab;
      obs_ack = 0; obs_err = 0; done_i = 0;
      wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = we; wb_adr = adr; wb_sel = sel; wb_i_dat = dat;
      junk(); tick();
      junk(); tick();
      exp_req = 1'b1; exp_dir = we; exp_io = adr[15:0]; beat[0] = cw_io_o;
      junk(); tick();
      exp_req = 1'b0; exp_io = {sel, 6'b0, adr[23:16]}; beat[1] = cw_io_o;
      if (we) begin
         junk(); tick();
         exp_io = dat; beat[2] = cw_io_o;
         if (rst_dat) begin
            i_rst = 1'b1; junk(); tick();
            set_idle(); exp_odat = '0;
            obs_ack += int'(wb_ack); obs_err += int'(wb_err);
            i_rst = 1'b0; wb_cyc = 1'b0; wb_stb = 1'b0;
            cw_ack = 1'b1; cw_err = 1'b0; tick();
            obs_ack += int'(wb_ack); obs_err += int'(wb_err);
            cw_ack = 1'b0; tick();
            obs_ack += int'(wb_ack); obs_err += int'(wb_err);
            return;
         end
      end
      junk(); tick();
      exp_io = '0;
      for (int i = 1; i <= int'(TO); i++) begin
         resp = (kind != 3) && (i == delay + 1);
         cw_ack = resp && (kind == 0 || kind == 2);
         cw_err = resp && (kind == 1 || kind == 2);
         cw_io_i = resp ? rdat : 16'($urandom);
         rd = cw_io_i;
         if (i == abort_at) begin
            wb_cyc = 1'b0; wb_stb = 1'b0;
         end
         tick();
         if (resp || i == int'(TO)) begin
            ab = (abort_at > 0) && (abort_at <= i);
            is_err = (kind != 0);
            exp_ack = !is_err && !ab;
            exp_err = is_err && !ab;
            if (!is_err && !we && !ab) exp_odat = rd;
            obs_ack += int'(wb_ack); obs_err += int'(wb_err);
            done_i = i;
            break;
         end
      end
      cw_ack = 1'b0; cw_err = 1'b0;
      if (!keep_stb) begin
         wb_cyc = 1'b0; wb_stb = 1'b0;
      end
      tick();
      set_idle();
      obs_ack += int'(wb_ack); obs_err += int'(wb_err);
   endtask

   initial begin
      int r0, a0;
      i_rst = 1'b1; wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0; wb_adr = '0; wb_sel = '0;
      wb_i_dat = '0; cw_io_i = '0; cw_ack = 1'b0; cw_err = 1'b0;
      tick();
      set_idle(); exp_odat = '0; chk_en = 1'b1;
      check("rst_io", 32'(cw_io_o), 32'h0);
      check("rst_odat", 32'(wb_o_dat), 32'h0);
      tick();
      i_rst = 1'b0;
      idle(2);

      txn(1'b0, 24'h00200C, 2'b11, 16'h0, 16'hBEEF, 1, 0, 1'b0, 0, 1'b0);
      check("t1_beat0", 32'(beat[0]), 32'h200C);
      check("t1_beat1", 32'(beat[1]), 32'hC000);
      check("t1_acks", 32'(obs_ack), 32'd1);
      check("t1_odat", 32'(wb_o_dat), 32'hBEEF);
      idle(1);

      txn(1'b1, 24'hFFE010, 2'b01, 16'h1234, 16'h0, 0, 0, 1'b0, 0, 1'b0);
      check("t2_beat0", 32'(beat[0]), 32'hE010);
      check("t2_beat1", 32'(beat[1]), 32'h40FF);
      check("t2_beat2", 32'(beat[2]), 32'h1234);
      check("t2_acks", 32'(obs_ack), 32'd1);
      check("t2_odat", 32'(wb_o_dat), 32'hBEEF);

      txn(1'b0, 24'h000100, 2'b11, 16'h0, 16'h5555, 0, 2, 1'b1, 0, 1'b0);
      check("t3_errs", 32'(obs_err), 32'd1);
      check("t3_acks", 32'(obs_ack), 32'd0);
      check("t3_odat", 32'(wb_o_dat), 32'hBEEF);
      txn(1'b0, 24'h000102, 2'b10, 16'h0, 16'h0102, 0, 0, 1'b0, 0, 1'b0);
      idle(1);

      txn(1'b0, 24'h123456, 2'b11, 16'h0, 16'h0, 0, 3, 1'b0, 0, 1'b0);
      check("t4_errs", 32'(obs_err), 32'd1);
      check("t4_wait_cycles", 32'(done_i), 32'd8);
      txn(1'b0, 24'h002000, 2'b11, 16'h0, 16'hA5A5, 2, 0, 1'b0, 0, 1'b0);
      check("t4_next_ack", 32'(obs_ack), 32'd1);
      check("t4_next_odat", 32'(wb_o_dat), 32'hA5A5);
      idle(2);

      r0 = req_cnt; a0 = 0;
      txn(1'b0, 24'h000040, 2'b11, 16'h0, 16'h1111, 0, 0, 1'b1, 0, 1'b0);
      a0 += obs_ack;
      txn(1'b0, 24'h000040, 2'b11, 16'h0, 16'h2222, 0, 0, 1'b0, 0, 1'b0);
      a0 += obs_ack;
      check("t5_req_pulses", 32'(req_cnt - r0), 32'd2);
      check("t5_gap_ge3", 32'(req_gap >= 3), 32'd1);
      check("t5_acks", 32'(a0), 32'd2);
      idle(1);

      txn(1'b1, 24'h00ABCD, 2'b11, 16'h7777, 16'h0, 0, 0, 1'b0, 0, 1'b1);
      check("t6_acks", 32'(obs_ack), 32'd0);
      check("t6_errs", 32'(obs_err), 32'd0);
      idle(2);

      txn(1'b0, 24'h000300, 2'b11, 16'h0, 16'h3333, 2, 0, 1'b0, 1, 1'b0);
      check("abort_acks", 32'(obs_ack), 32'd0);
      idle(1);

      for (int n = 0; n < 300; n++) begin
         int  kind, ab;
         bit  keep;
         kind = $urandom_range(0, 9);
         kind = (kind < 6) ? 0 : (kind < 8) ? 1 : (kind < 9) ? 2 : 3;
         ab = ($urandom_range(0, 15) == 0) ? int'($urandom_range(1, 3)) : 0;
         keep = ($urandom_range(0, 3) == 0) && (ab == 0);
         txn(1'($urandom_range(0, 1)), 24'($urandom), 2'($urandom), 16'($urandom),
             16'($urandom), int'($urandom_range(0, TO - 1)), kind, keep, ab, 1'b0);
         if (!keep) idle(int'($urandom_range(0, 3)));
      end
      idle(3);

      chk_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/wb_comp.md
Name: wb_comp

Overview:
- Core-side end of the compressed wishbone (cw) pin bus; the mirror of the board-side decompressor.
- Accepts 16-bit wishbone requests from the core as a slave and serializes each request onto the 16-bit multiplexed cw pins: address low, then address high and select, then write data.
- Waits for cw_ack or cw_err from the far end, then completes the wishbone cycle toward the core.
- All cw outputs and all wishbone response outputs are registered.

Parameters:
- ADDR_W, 24, wishbone address width; upper 8 bits are sent in the second beat.
- DATA_W, 16, data width; equals cw pin width.
- TIMEOUT, 255, cycles spent in WAIT without ack/err before a local error is raised; 0 disables the timeout.

Ports:
- i_clk  in  1  bus clock; also driven out as cw_clk.
- i_rst  in  1  synchronous, active-high reset.
- wb_cyc  in  1  wishbone cycle from core.
- wb_stb  in  1  wishbone strobe.
- wb_we  in  1  1 = write.
- wb_adr  in  ADDR_W  word address.
- wb_sel  in  2  byte selects.
- wb_i_dat  in  DATA_W  write data from core.
- wb_o_dat  out  DATA_W  read data to core.
- wb_ack  out  1  one-cycle completion pulse.
- wb_err  out  1  one-cycle error pulse.
- cw_req  out  1  start-of-transfer strobe, first beat only.
- cw_dir  out  1  1 = write; held for the whole transfer.
- cw_io_o  out  DATA_W  multiplexed address/data pins.
- cw_io_i  in  DATA_W  read data from far end, valid with cw_ack.
- cw_ack  in  1  far-end completion.
- cw_err  in  1  far-end error.
- cw_clk  out  1  equals i_clk.
- cw_rst  out  1  equals i_rst.

Behaviour:
- Reset values: all registered outputs are 0 (cw_req, cw_dir, cw_io_o, wb_ack, wb_err, wb_o_dat); state = IDLE; timeout counter = 0.
- Reset is honoured in any state. Mid-transfer reset abandons the transfer with no ack/err pulse.
- State IDLE: cw_req=0, cw_io_o=0.
  - On wb_cyc & wb_stb: latch wb_we, wb_adr, wb_sel, wb_i_dat.
  - Next edge: cw_req=1, cw_dir=we, cw_io_o=adr[15:0]; go to AHI.
- State AHI: cw_req=0, cw_io_o={sel[1:0], 6'b0, adr[23:16]}.
  - we=1 → DATA; we=0 → WAIT.
- State DATA: cw_io_o = latched write data → WAIT.
- State WAIT: cw_io_o=0; timeout counter increments each cycle.
  - cw_err: wb_err=1 for one cycle → DONE.
  - Otherwise cw_ack: on a read, wb_o_dat <= cw_io_i; wb_ack=1 for one cycle → DONE.
  - ack and err sampled in the same cycle: err wins, no ack pulse, wb_o_dat unchanged.
  - Counter reaches TIMEOUT (TIMEOUT≠0): wb_err pulse → DONE.
  - ack/err sampled in AHI or DATA is ignored; only WAIT samples them.
- State DONE: one dead cycle, no new request accepted; clear cw_dir and counter → IDLE. This stops a still-asserted stb from re-issuing the same request.
- Core abort: if wb_cyc drops while in AHI, DATA or WAIT, the cw transfer still runs to ack/err or timeout, but wb_ack/wb_err are suppressed.
- Latency (ack returned immediately by far end), stb sampled at edge 0:
  - Read: req at edge 1, AHI at edge 2, WAIT at edge 3; cw_ack sampled at edge 4 gives wb_ack high after edge 4 → 5 cycles total.
  - Write: one extra DATA beat → 6 cycles.
- Throughput: one transfer per read + 2 cycles (DONE + IDLE accept).
- wb_o_dat holds the last read value until the next successful read.
- Width rules: the address high beat zero-pads bits [13:8]; ADDR_W < 24 zero-extends; no address arithmetic is done locally.

Test Plan:
- Read, adr=0x00200C, sel=2'b11, far end acks 2 cycles into WAIT with cw_io_i=0xBEEF → cw_io_o beats 0x200C (req=1), 0xC000 (req=0), dir=0; wb_ack one cycle with wb_o_dat=0xBEEF.
- Write, adr=0xFFE010, sel=2'b01, dat=0x1234, immediate ack → beats 0xE010, 0x40FF, 0x1234; dir=1 for all 3; wb_ack single pulse; wb_o_dat unchanged.
- Read where cw_ack and cw_err are high in the same cycle → wb_err pulse, no wb_ack, wb_o_dat unchanged; next request starts only after the DONE cycle.
- TIMEOUT=8, no response → wb_err exactly 8 cycles after entering WAIT; then IDLE; a following read to 0x002000 completes normally.
- wb_stb held high across two back-to-back reads → exactly two cw_req pulses separated by ≥2 idle cycles; two wb_ack pulses.
- i_rst asserted during DATA of a write → next cycle all outputs 0 and no ack/err pulse; a late cw_ack after reset is ignored.
